seven_segment_scan: RTL
=======================

Name: seven_segment_scan

Overview:
Parametrised multi-digit seven-segment display driver. It accepts a binary value through a valid/busy handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle). It then time-multiplexes NUM_DIGITS digits with a programmable refresh divider. Adds per-digit decimal points, leading-zero blanking and overflow indication. It sits between application logic (score/counter values) and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8)
BIN_W, 27, width of binary input
REFRESH_DIV, 100000, clk cycles each digit is lit (>=1)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
val_in  input  BIN_W  binary value to display
val_valid_in  input  1  load request; sampled only when busy_out=0
busy_out  output  1  conversion in progress; loads ignored
dp_in  input  NUM_DIGITS  decimal point per digit, bit i = digit i (digit 0 rightmost); 1 = lit
blank_zeros_in  input  1  1 = blank leading zeros
cat_out  output  8  active-low cathodes; [7]=DP, [6]=A ... [0]=G
an_out  output  NUM_DIGITS  active-low anodes, one-hot low
overflow_out  output  1  1 = last committed value >= 10^NUM_DIGITS

Behaviour:
- Reset state:
  - FSM=IDLE, busy_out=0, overflow_out=0.
  - Display register (NUM_DIGITS*4 bits) = 0, digit index=0, refresh counter=0.
  - an_out = ~1 (digit 0 on), cat_out = 8'b1000_0001 ('0', DP off, assuming dp_in[0]=0).
- Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: on val_valid_in=1, latch val_in into the shift register, clear the BCD work register and sticky overflow flag, go to SHIFT. busy_out=1 from the next cycle.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left one bit. Any 1 shifted out of the top nibble sets the sticky overflow flag.
  - DONE: one cycle. Commit the BCD work register to the display register and the overflow flag to overflow_out, go to IDLE.
  - busy_out is high for exactly BIN_W+1 cycles. The display changes on the edge leaving DONE.
  - The old value is displayed throughout conversion, with no partial updates.
  - val_valid_in while busy_out=1 (including the DONE cycle) is ignored; nothing is queued.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - REFRESH_DIV=1 advances every cycle.
  - Scanning runs independently of the FSM.
- Output mapping for current digit i (registered, one cycle after index change):
  - an_out = ~(1<<i).
  - cat_out[7] = ~dp_in[i].
  - cat_out[6:0] = active-low pattern of the nibble; codes 10-15 blank.
- Leading-zero blanking: when blank_zeros_in=1, digit i>0 is blank (segments 1111111) if it and all higher digits are 0. Digit 0 is never blanked. DP remains governed by dp_in.
- Overflow display: when overflow_out=1, every digit shows '-' (1111110), regardless of blanking.
- Reset mid-conversion: aborts to IDLE and clears the display register.

Decomposition:
- Package seven_segment_pkg:
  - FSM state enum.
  - 7-bit segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - Function computing the counter width from REFRESH_DIV.
- Sub-module bin2bcd_seq (parametrised BIN_W, NUM_DIGITS): sequential double-dabble with start/busy/done/overflow.
- Top level owns the scan counter, blanking and output registers.

Test Plan (NUM_DIGITS=4, BIN_W=14, REFRESH_DIV=4):
1. Assert rst_in asynchronously mid-cycle -> an_out=1110, cat_out=10000001, busy_out=0, overflow_out=0 immediately; scan advances every 4 cycles through 1110,1101,1011,0111, then back to 1110.
2. Load 1234 -> busy_out high 15 cycles; then digits 0..3 show 1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1).
3. blank_zeros_in=1, load 42 -> digits 3,2 show 1111111, digit 1 shows '4', digit 0 shows '2'. Load 0 -> digits 3..1 blank, digit 0 shows 0000001.
4. Load 12000 -> overflow_out=1, all digits 1111110. Then load 9999 -> overflow_out=0, all digits 0000100.
5. Pulse val_valid_in with 5555 on cycle 3 of a 1234 conversion -> ignored; display shows 1234. Assert rst_in during SHIFT -> display 0000, busy_out=0.
6. dp_in=0100 with value 1234 -> cat_out[7]=0 only while an_out=1011.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types, segment patterns and sizing helpers for the seven-segment scan driver.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  // Active-low segment patterns, bit order A..G (bit 6 = A, bit 0 = G)
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_scan_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, sticky overflow when
// a set bit leaves the top BCD nibble.
module bin2bcd_seq
  import seven_segment_pkg::*;
#(
  parameter int unsigned BIN_W      = 27,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NUM_DIGITS*4-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int unsigned BW = NUM_DIGITS * 4;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        ovf_d          = ovf_q | adj[BW-1];
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/seven_segment_scan.sv
// Multi-digit seven-segment driver: owns the committed display value, the refresh
// scan, leading-zero blanking, overflow dashes and the registered pin outputs.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned BIN_W       = 27,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [BIN_W-1:0]      val_in,
  input  logic                  val_valid_in,
  output logic                  busy_out,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_zeros_in,
  output logic [7:0]            cat_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  overflow_out
);

  localparam int unsigned CW = cnt_width(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = NUM_DIGITS * 4;
  localparam logic [NUM_DIGITS-1:0] AN_RST = ~(NUM_DIGITS'(1));

  logic          conv_done, conv_ovf;
  logic [DW-1:0] conv_bcd;

  logic [DW-1:0]         disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            cat_q, cat_d;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic [6:0]            seg;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .start_i (val_valid_in),
    .bin_i   (val_in),
    .busy_o  (busy_out),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (conv_done) begin
      disp_d = conv_bcd;
      ovf_d  = conv_ovf;
    end

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // A digit is a leading zero only if it and every more-significant digit are zero
    nib      = disp_q[{idx_q, 2'b00} +: 4];
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j >= 32'(idx_q) && disp_q[j*4 +: 4] != 4'd0) upper_nz = 1'b1;
    end

    if (ovf_q)                                           seg = SEG_DASH;
    else if (blank_zeros_in && idx_q != '0 && !upper_nz) seg = SEG_BLANK;
    else                                                 seg = seg_decode(nib);

    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    cat_d = {~dp_in[idx_q], seg};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= AN_RST;
      cat_q  <= {1'b1, SEG_0};
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      cat_q  <= cat_d;
    end
  end

  assign an_out       = an_q;
  assign cat_out      = cat_q;
  assign overflow_out = ovf_q;

endmodule
